pipe_stage_skid: RTL and testbench

Parametrised, handshaked pipeline stage register that replaces the fixed-field, enable-only stage registers between ID/RF/EX/MEM/WB. It carries an opaque DATA_W-bit payload with valid/ready flow control and a one-entry skid buffer, so the upstream ready signal is registered and full throughput is kept under backpressure. Flush converts the stage to a NOP. Saturating stall and bubble counters support performance debug.

---
 rtl/pipe_pkg.sv | 12 +
 rtl/pipe_sat_counter.sv | 24 ++
 rtl/pipe_stage_skid.sv | 100 ++++++++++
 tb/tb_pipe_stage_skid.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and defaults for the handshaked pipeline stage registers.
package pipe_pkg;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } stage_occ_e;

  localparam int PIPE_CNT_W_DEFAULT = 16;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module pipe_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count_reg <= '0;
    end else if (inc && (count_reg != {W{1'b1}})) begin
      count_reg <= count_reg + W'(1);
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage with a one-entry skid buffer so in_ready is
// registered; flush turns the stage into a NOP. Includes stall/bubble counters.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int              DATA_W    = 64,
  parameter logic [DATA_W-1:0] NOP_VALUE = '0,
  parameter int              CNT_W     = PIPE_CNT_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic              main_valid_reg;
  logic [DATA_W-1:0] main_data_reg;
  logic              skid_valid_reg;
  logic [DATA_W-1:0] skid_data_reg;
  stage_occ_e        occ;
  logic              fire_in;
  logic              fire_out;

  always_comb begin
    occ = OCC_EMPTY;
    case ({skid_valid_reg, main_valid_reg})
      2'b00:   occ = OCC_EMPTY;
      2'b01:   occ = OCC_ONE;
      default: occ = OCC_FULL;
    endcase
  end

  // in_ready depends only on registered state (and reset), never on out_ready.
  assign in_ready  = !skid_valid_reg && !rst;
  assign out_valid = main_valid_reg;
  assign out_data  = main_data_reg;
  assign occupancy = occ;
  assign fire_in   = in_valid && in_ready;
  assign fire_out  = main_valid_reg && out_ready;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      main_valid_reg <= 1'b0;
      skid_valid_reg <= 1'b0;
      main_data_reg  <= NOP_VALUE;
      skid_data_reg  <= NOP_VALUE;
    end else begin
      case (occ)
        OCC_EMPTY: begin
          if (fire_in) begin
            main_valid_reg <= 1'b1;
            main_data_reg  <= in_data;
          end
        end
        OCC_ONE: begin
          if (fire_in && fire_out) begin
            main_data_reg <= in_data;
          end else if (fire_in) begin
            skid_valid_reg <= 1'b1;
            skid_data_reg  <= in_data;
          end else if (fire_out) begin
            main_valid_reg <= 1'b0;
          end
        end
        default: begin
          if (fire_out) begin
            main_data_reg  <= skid_data_reg;
            skid_valid_reg <= 1'b0;
          end
        end
      endcase
    end
  end

  pipe_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (main_valid_reg && !out_ready),
    .count (stall_cnt)
  );

  pipe_sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (!main_valid_reg && out_ready),
    .count (bubble_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: vector table, directed corner
// sequences and random traffic against a queue-based reference model.
module tb_pipe_stage_skid;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [1:0]  occupancy;
  logic        cnt_clr;
  logic [3:0]  stall_cnt;
  logic [3:0]  bubble_cnt;

  pipe_stage_skid #(
    .DATA_W    (16),
    .NOP_VALUE (16'h0000),
    .CNT_W     (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .occupancy  (occupancy),
    .cnt_clr    (cnt_clr),
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: FIFO of capacity 2 plus the last value shown at the output.
  logic [15:0] q[$];
  logic [15:0] m_hold = 16'h0000;
  int          m_stall = 0;
  int          m_bubble = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic f, input logic iv,
                      input logic [15:0] d, input logic ordy, input logic clr);
    bit rdy;
    bit ov;
    logic [15:0] popped;
    rst = r; flush = f; in_valid = iv; in_data = d; out_ready = ordy; cnt_clr = clr;
    #1;
    rdy = (q.size() < 2) && !r;
    ov  = (q.size() > 0);
    chk("in_ready_pre", int'(in_ready), int'(rdy));
    @(posedge clk);
    if (r) begin
      q.delete(); m_hold = 16'h0000; m_stall = 0; m_bubble = 0;
    end else begin
      if (clr) begin
        m_stall = 0; m_bubble = 0;
      end else begin
        if (ov && !ordy && m_stall < 15) m_stall++;
        if (!ov && ordy && m_bubble < 15) m_bubble++;
      end
      if (f) begin
        q.delete(); m_hold = 16'h0000;
      end else begin
        if (ov && ordy) popped = q.pop_front();
        if (iv && rdy) q.push_back(d);
        if (q.size() > 0) m_hold = q[0];
      end
    end
    @(negedge clk);
    chk("out_valid", int'(out_valid), int'(q.size() > 0));
    chk("out_data", int'(out_data), int'(m_hold));
    chk("occupancy", int'(occupancy), q.size());
    chk("in_ready", int'(in_ready), int'((q.size() < 2) && !r));
    chk("stall_cnt", int'(stall_cnt), m_stall);
    chk("bubble_cnt", int'(bubble_cnt), m_bubble);
  endtask

  typedef struct {
    logic        flush;
    logic        iv;
    logic [15:0] d;
    logic        ordy;
    logic        ov;
    logic [15:0] od;
    logic [1:0]  occ;
    logic        ir;
  } vec_t;

  function automatic vec_t mk(logic f, logic iv, logic [15:0] d, logic ordy,
                              logic ov, logic [15:0] od, logic [1:0] occ, logic ir);
    vec_t v;
    v.flush = f; v.iv = iv; v.d = d; v.ordy = ordy;
    v.ov = ov; v.od = od; v.occ = occ; v.ir = ir;
    return v;
  endfunction

  vec_t vecs[10];

  initial begin
    vecs[0] = mk(0, 1, 16'h00A0, 1, 1, 16'h00A0, 2'd1, 1);
    vecs[1] = mk(0, 1, 16'h00A1, 1, 1, 16'h00A1, 2'd1, 1);
    vecs[2] = mk(0, 1, 16'h00A2, 0, 1, 16'h00A1, 2'd2, 0);
    vecs[3] = mk(0, 1, 16'h00A3, 0, 1, 16'h00A1, 2'd2, 0);
    vecs[4] = mk(0, 0, 16'h0000, 1, 1, 16'h00A2, 2'd1, 1);
    vecs[5] = mk(0, 0, 16'h0000, 1, 0, 16'h00A2, 2'd0, 1);
    vecs[6] = mk(0, 1, 16'h00B0, 0, 1, 16'h00B0, 2'd1, 1);
    vecs[7] = mk(0, 1, 16'h00B1, 0, 1, 16'h00B0, 2'd2, 0);
    vecs[8] = mk(1, 1, 16'hFFFF, 0, 0, 16'h0000, 2'd0, 1);
    vecs[9] = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 2'd0, 1);

    // Reset state
    step(1, 0, 0, 16'h0, 0, 0);
    step(1, 0, 1, 16'h1234, 1, 0);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_occupancy", int'(occupancy), 0);

    // Streaming 1..8 with out_ready held high
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 1, 16'(i + 1), 1, 0);
      chk("stream_data", int'(out_data), i + 1);
      chk("stream_ready", int'(in_ready), 1);
    end
    step(0, 0, 0, 16'h0, 1, 0);

    // Backpressure and flush-in-FULL table
    for (int i = 0; i < 10; i++) begin
      step(0, vecs[i].flush, vecs[i].iv, vecs[i].d, vecs[i].ordy, 0);
      chk("vec_out_valid", int'(out_valid), int'(vecs[i].ov));
      chk("vec_out_data", int'(out_data), int'(vecs[i].od));
      chk("vec_occupancy", int'(occupancy), int'(vecs[i].occ));
      chk("vec_in_ready", int'(in_ready), int'(vecs[i].ir));
      $display("vec %0d: out_valid=%0b out_data=%h occ=%0d in_ready=%0b",
               i, out_valid, out_data, occupancy, in_ready);
    end

    // Stall counter saturation, then clear during a qualifying cycle
    step(0, 0, 0, 16'h0, 0, 1);
    step(0, 0, 1, 16'h00C0, 0, 0);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 16'h0, 0, 0);
    chk("stall_sat", int'(stall_cnt), 15);
    step(0, 0, 0, 16'h0, 0, 1);
    chk("stall_clr", int'(stall_cnt), 0);

    // Bubbles from EMPTY
    step(0, 0, 0, 16'h0, 1, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 16'h0, 1, 0);
    chk("bubble_five", int'(bubble_cnt), 5);
    chk("bubble_stall", int'(stall_cnt), 0);

    // Reset while FULL
    step(0, 0, 1, 16'h00D0, 0, 0);
    step(0, 0, 1, 16'h00D1, 0, 0);
    chk("pre_rst_occ", int'(occupancy), 2);
    step(1, 0, 1, 16'h00D2, 0, 0);
    chk("mid_rst_ready", int'(in_ready), 0);
    chk("mid_rst_occ", int'(occupancy), 0);
    chk("mid_rst_data", int'(out_data), 0);
    step(0, 0, 0, 16'h0, 0, 0);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 29) == 0),
           ($urandom_range(0, 3) != 0), 16'($urandom), ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 39) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
